// File: rtl/composite_timing_gen_pkg.sv
// Shared levels, half-line types and PAL default timing for the composite generator.
// COMPOSITE_INTERLACE_EN selects the 625-line interlaced frame; otherwise 312-line progressive.
package composite_pkg;

    localparam logic [2:0] SYNC  = 3'b000;
    localparam logic [2:0] BLANK = 3'b001;

    typedef enum logic [1:0] {
        HT_NORMAL,
        HT_EQ,
        HT_BROAD,
        HT_BLANK
    } half_t;

    localparam int LINE_CLKS_DEF  = 1728;
    localparam int HSYNC_CLKS_DEF = 127;
    localparam int EQ_CLKS_DEF    = 63;
    localparam int ACT_START_DEF  = 281;
    localparam int ACT_END_DEF    = 1685;

    // First and last active lines of each field, frame-relative.
    localparam logic [9:0] F0_FIRST = 10'd22;
    localparam logic [9:0] F0_LAST  = 10'd309;
    localparam logic [9:0] F1_FIRST = 10'd334;
    localparam logic [9:0] F1_LAST  = 10'd621;

`ifdef COMPOSITE_INTERLACE_EN
    localparam int NUM_LINES = 625;
`else
    localparam int NUM_LINES = 312;
`endif

    typedef struct packed {
        half_t first;
        half_t second;
        logic  active;
        logic  field;
    } line_info_t;

    typedef struct packed {
        logic       de;
        logic [2:0] level;
    } stage_t;

endpackage

// File: rtl/composite_timing_gen_if.sv
// Pixel-side bundle of the composite timing generator.
interface composite_timing_gen_if;
    // No handshake: outputs are valid every cycle; de qualifies x/y, and the pixel
    // source must present pix_in for (x,y) exactly PIX_LATENCY cycles after them.
    logic [2:0]  pix_in;
    logic        de;
    logic [10:0] x;
    logic [8:0]  y;
    logic        field;
    logic        frame_start;
    logic [2:0]  sig;

    modport master (
        input  pix_in,
        output de, x, y, field, frame_start, sig
    );

    modport slave (
        output pix_in,
        input  de, x, y, field, frame_start, sig
    );
endinterface

// File: rtl/composite_timing_gen_line_decoder.sv
// Combinational line map: line number -> half-line types, active flag and field.
// The interlaced lines 312..624 only exist when COMPOSITE_INTERLACE_EN is defined.
module composite_line_decoder
    import composite_pkg::*;
(
    input  logic [9:0]  line,
    output line_info_t  info
);

    always_comb begin
        info.first  = HT_NORMAL;
        info.second = HT_NORMAL;
        info.active = 1'b0;
        info.field  = 1'b0;
        if (line <= 10'd1) begin
            info.first  = HT_BROAD;
            info.second = HT_BROAD;
        end else if (line == 10'd2) begin
            info.first  = HT_BROAD;
            info.second = HT_EQ;
        end else if (line <= 10'd4) begin
            info.first  = HT_EQ;
            info.second = HT_EQ;
        end else if (line <= F0_LAST) begin
            info.active = (line >= F0_FIRST);
        end else if (line <= 10'd311) begin
            info.first  = HT_EQ;
            info.second = HT_EQ;
`ifdef COMPOSITE_INTERLACE_EN
        end else if (line == 10'd312) begin
            info.first  = HT_EQ;
            info.second = HT_BROAD;
        end else if (line <= 10'd314) begin
            info.first  = HT_BROAD;
            info.second = HT_BROAD;
        end else if (line <= 10'd316) begin
            info.first  = HT_EQ;
            info.second = HT_EQ;
        end else if (line == 10'd317) begin
            info.first  = HT_EQ;
            info.second = HT_BLANK;
        end else if (line <= F1_LAST) begin
            info.active = (line >= F1_FIRST);
        end else if (line == 10'd622) begin
            info.second = HT_EQ;
        end else begin
            info.first  = HT_EQ;
            info.second = HT_EQ;
`endif
        end
`ifdef COMPOSITE_INTERLACE_EN
        info.field = (line >= 10'd313);
`endif
    end

endmodule

// File: rtl/composite_timing_gen.sv
// PAL composite timing generator: line/pixel counters, sync level generation,
// registered pixel coordinates and a PIX_LATENCY-deep delay line feeding the 3-bit DAC.
module composite_timing_gen
    import composite_pkg::*;
#(
    parameter int LINE_CLKS   = LINE_CLKS_DEF,
    parameter int HSYNC_CLKS  = HSYNC_CLKS_DEF,
    parameter int EQ_CLKS     = EQ_CLKS_DEF,
    parameter int ACT_START   = ACT_START_DEF,
    parameter int ACT_END     = ACT_END_DEF,
    parameter int PIX_LATENCY = 0
) (
    input logic                    sys_clk,
    input logic                    sys_rst,
    composite_timing_gen_if.master bus
);

    if (ACT_END > LINE_CLKS || HSYNC_CLKS >= LINE_CLKS / 2 || (LINE_CLKS % 2) != 0 ||
        LINE_CLKS > 2048 || ACT_START >= ACT_END || PIX_LATENCY < 0 || PIX_LATENCY > 4)
    begin : g_bad_params
        $error("composite_timing_gen: illegal timing parameter combination");
    end

    localparam logic [10:0] LAST_HC   = 11'(LINE_CLKS - 1);
    localparam logic [10:0] HALF      = 11'(LINE_CLKS / 2);
    localparam logic [10:0] HSYNC_W   = 11'(HSYNC_CLKS);
    localparam logic [10:0] EQ_W      = 11'(EQ_CLKS);
    localparam logic [10:0] BROAD_W   = 11'(LINE_CLKS / 2 - HSYNC_CLKS);
    localparam logic [10:0] ACT_S     = 11'(ACT_START);
    localparam logic [10:0] ACT_E     = 11'(ACT_END);
    localparam logic [9:0]  LAST_LINE = 10'(NUM_LINES - 1);

    logic [10:0] hc;
    logic [9:0]  line;
    line_info_t  info;
    logic        second_half;
    logic [10:0] pos;
    half_t       ht;
    logic [2:0]  level;
    logic        de_nxt;
    stage_t      dly [PIX_LATENCY+1];

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            hc   <= '0;
            line <= '0;
        end else if (hc == LAST_HC) begin
            hc   <= '0;
            line <= (line == LAST_LINE) ? '0 : line + 10'd1;
        end else begin
            hc <= hc + 11'd1;
        end
    end

    composite_line_decoder u_decoder (
        .line (line),
        .info (info)
    );

    // A NORMAL half compares the raw hc, so its second half never reaches the sync window.
    always_comb begin
        second_half = (hc >= HALF);
        pos         = second_half ? hc - HALF : hc;
        ht          = second_half ? info.second : info.first;
        level       = BLANK;
        case (ht)
            HT_NORMAL: if (hc < HSYNC_W)  level = SYNC;
            HT_EQ:     if (pos < EQ_W)    level = SYNC;
            HT_BROAD:  if (pos < BROAD_W) level = SYNC;
            default:   level = BLANK;
        endcase
        de_nxt = info.active && (hc >= ACT_S) && (hc < ACT_E);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bus.de          <= 1'b0;
            bus.x           <= '0;
            bus.y           <= '0;
            bus.field       <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            bus.de          <= de_nxt;
            bus.x           <= de_nxt ? hc - ACT_S : '0;
            if (de_nxt) begin
                bus.y <= info.field ? 9'(line - F1_FIRST) : 9'(line - F0_FIRST);
            end
            bus.field       <= info.field;
            bus.frame_start <= (line == '0) && (hc == '0);
        end
    end

    // Level and de travel together so the sync edge stays aligned with the pixel edge.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int k = 0; k <= PIX_LATENCY; k++) begin
                dly[k] <= '{de: 1'b0, level: BLANK};
            end
            bus.sig <= BLANK;
        end else begin
            dly[0] <= '{de: de_nxt, level: level};
            for (int k = 1; k <= PIX_LATENCY; k++) begin
                dly[k] <= dly[k-1];
            end
            bus.sig <= dly[PIX_LATENCY].de ? bus.pix_in : dly[PIX_LATENCY].level;
        end
    end

endmodule

// File: tb/tb_composite_timing_gen.sv
// Bench for composite_timing_gen with shortened lines (80 clocks) and PIX_LATENCY = 3.
// Expected sig runs, de runs and frame_start cycles are queued per line; a monitor pops them.
module tb_composite_timing_gen;

    localparam int LC  = 80;
    localparam int HS  = 6;
    localparam int EQW = 3;
    localparam int AS  = 14;
    localparam int AE  = 74;
    localparam int LAT = 3;
`ifdef COMPOSITE_INTERLACE_EN
    localparam int NL = 625;
`else
    localparam int NL = 312;
`endif
    localparam int FRAME = NL * LC;

    // Hand-derived run lengths for the 80-clock line (half = 40).
    localparam int BR_S = 34, BR_B = 6;        // broad: 40-6 sync
    localparam int EQ_S = 3,  EQ_B = 37;       // equalising
    localparam int NL_S = 6,  NL_PRE = 8;      // normal sync, back porch to 14
    localparam int NL_PIX = 60, NL_POST = 6;   // 14..73 active, 74..79 blank
    localparam int NL_IDLE = 74;               // inactive normal line after sync
    localparam int EQBL_B = 77;                // eq half followed by an all-blank half
    localparam int NEQ_B = 34;                 // normal first half then eq second half

    localparam logic [2:0] S_LVL = 3'b000;
    localparam logic [2:0] B_LVL = 3'b001;
    localparam logic [2:0] PIX   = 3'b111;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    composite_timing_gen_if bus ();

    composite_timing_gen #(
        .LINE_CLKS   (LC),
        .HSYNC_CLKS  (HS),
        .EQ_CLKS     (EQW),
        .ACT_START   (AS),
        .ACT_END     (AE),
        .PIX_LATENCY (LAT)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    logic [18:0] sig_q [$];   // {level, run length}
    logic [25:0] de_q  [$];   // {field, y, run length}
    logic [32:0] fs_q  [$];   // {field, y, cycle after release}
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_run(input logic [2:0] lvl, input int len);
        sig_q.push_back({lvl, 16'(len)});
    endtask

    task automatic push_broad();
        push_run(S_LVL, BR_S);
        push_run(B_LVL, BR_B);
    endtask

    task automatic push_eq();
        push_run(S_LVL, EQ_S);
        push_run(B_LVL, EQ_B);
    endtask

    task automatic push_normal(input bit act, input int yv, input bit fld);
        push_run(S_LVL, NL_S);
        if (act) begin
            push_run(B_LVL, NL_PRE);
            push_run(PIX, NL_PIX);
            push_run(B_LVL, NL_POST);
            de_q.push_back({fld, 9'(yv), 16'(NL_PIX)});
        end else begin
            push_run(B_LVL, NL_IDLE);
        end
    endtask

    task automatic push_line(input int l);
        if (l <= 1) begin
            push_broad(); push_broad();
        end else if (l == 2) begin
            push_broad(); push_eq();
        end else if (l <= 4) begin
            push_eq(); push_eq();
        end else if (l <= 309) begin
            push_normal(l >= 22, l - 22, 1'b0);
        end else if (l <= 311) begin
            push_eq(); push_eq();
        end else if (l == 312) begin
            push_eq(); push_broad();
        end else if (l <= 314) begin
            push_broad(); push_broad();
        end else if (l <= 316) begin
            push_eq(); push_eq();
        end else if (l == 317) begin
            push_run(S_LVL, EQ_S);
            push_run(B_LVL, EQBL_B);
        end else if (l <= 621) begin
            push_normal(l >= 334, l - 334, 1'b1);
        end else if (l == 622) begin
            push_run(S_LVL, NL_S);
            push_run(B_LVL, NEQ_B);
            push_eq();
        end else begin
            push_eq(); push_eq();
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sig"}, bus.sig, B_LVL);
        check({tag, "_de"}, bus.de, 0);
        check({tag, "_x"}, bus.x, 0);
        check({tag, "_y"}, bus.y, 0);
        check({tag, "_field"}, bus.field, 0);
        check({tag, "_frame_start"}, bus.frame_start, 0);
    endtask

    task automatic wait_q(input string tag, input int sig_left, input int de_left, input int limit);
        int cyc = 0;
        while ((sig_q.size() > sig_left || de_q.size() > de_left || fs_q.size() > 0) && cyc < limit) begin
            @(negedge sys_clk);
            cyc++;
        end
        checks++;
        if (cyc >= limit) begin
            errors++;
            $display("FAIL %s_timeout: queues left sig %0d de %0d fs %0d, required sig %0d de %0d fs 0",
                     tag, sig_q.size(), de_q.size(), fs_q.size(), sig_left, de_left);
        end
    endtask

    // Pixel source: drive 111 only while de from LAT cycles ago is high.
    logic [LAT:0] de_hist;
    initial begin
        de_hist = '0;
        bus.pix_in = 3'b000;
        forever begin
            @(posedge sys_clk);
            #1;
            de_hist = {de_hist[LAT-1:0], bus.de};
            bus.pix_in = de_hist[LAT] ? PIX : 3'b000;
        end
    end

    // Monitor: closes sig runs, de runs and frame_start pulses and compares against the queues.
    int n;
    logic [2:0] run_lvl;
    int run_len;
    int de_len;
    logic [8:0] de_y;
    logic de_field;
    int x_bad;
    logic [18:0] se;
    logic [25:0] dexp;
    logic [32:0] fexp;

    initial begin
        n = 0; run_len = 0; de_len = 0; x_bad = 0;
        run_lvl = '0; de_y = '0; de_field = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                n = 0; run_len = 0; de_len = 0; x_bad = 0;
            end else begin
                n++;
                if (n >= LAT + 2) begin
                    if (run_len == 0) begin
                        run_lvl = bus.sig; run_len = 1;
                    end else if (bus.sig === run_lvl) begin
                        run_len++;
                    end else begin
                        if (sig_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL sig_run_extra: got level %0d len %0d required none", run_lvl, run_len);
                        end else begin
                            se = sig_q.pop_front();
                            check("sig_lvl", run_lvl, se[18:16]);
                            check("sig_len", run_len, se[15:0]);
                        end
                        run_lvl = bus.sig; run_len = 1;
                    end
                end
                if (bus.de === 1'b1) begin
                    if (de_len == 0) begin
                        de_y = bus.y; de_field = bus.field;
                    end
                    if (bus.x !== 11'(de_len)) x_bad++;
                    de_len++;
                end else begin
                    if (bus.x !== 11'd0) x_bad++;
                    if (de_len != 0) begin
                        if (de_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL de_run_extra: got y %0d len %0d required none", de_y, de_len);
                        end else begin
                            dexp = de_q.pop_front();
                            check("de_len", de_len, dexp[15:0]);
                            check("de_y", de_y, dexp[24:16]);
                            check("de_field", de_field, dexp[25]);
                            check("x_seq_bad", x_bad, 0);
                        end
                        de_len = 0; x_bad = 0;
                    end
                end
                if (bus.frame_start === 1'b1) begin
                    if (fs_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL frame_start_extra: got pulse at cycle %0d required none", n);
                    end else begin
                        fexp = fs_q.pop_front();
                        check("fs_cycle", n, fexp[22:0]);
                        check("fs_y", bus.y, fexp[31:23]);
                        check("fs_field", bus.field, fexp[32]);
                    end
                end
            end
        end
    end

    initial begin
        sys_rst = 1'b1;
        repeat (10) @(posedge sys_clk);
        @(negedge sys_clk);
        check_reset("init");
        fs_q.push_back({1'b0, 9'd0, 23'd1});
        fs_q.push_back({1'b0, 9'd287, 23'(1 + FRAME)});
        for (int l = 0; l < NL; l++) push_line(l);
        for (int l = 0; l <= 150; l++) push_line(l);
        #1 sys_rst = 1'b0;

        // Run into the pixel region of line 150 of the second frame, then reset mid-line.
        wait_q("frame", 2, 1, (NL + 151) * LC + 200);
        repeat (18) @(posedge sys_clk);
        #3 sys_rst = 1'b1;
        #1 check_reset("mid");
        check("mid_sig_left", sig_q.size(), 2);
        check("mid_de_left", de_q.size(), 1);
        sig_q.delete();
        de_q.delete();
        repeat (5) @(negedge sys_clk);
        fs_q.push_back({1'b0, 9'd0, 23'd1});
        for (int l = 0; l < 30; l++) push_line(l);
        #1 sys_rst = 1'b0;
        wait_q("restart", 0, 0, 30 * LC + 200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
